// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the instruction-fetch slice.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

  typedef enum logic {
    RUN_IDLE,
    RUN_ACTIVE
  } run_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// IMEM request/response bus and IF->ID presentation signals of the fetch stage.
interface if_fetch_unit_if;

  logic [31:0] imem_addr;
  logic        imem_re;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc_out;
  logic [31:0] if_instr_out;
  logic        if_valid;

  modport master (
    output imem_addr, imem_re,
    input  imem_rdata,
    output if_pc_out, if_instr_out, if_valid
  );

  modport slave (
    input  imem_addr, imem_re,
    output imem_rdata,
    input  if_pc_out, if_instr_out, if_valid
  );

endinterface

// File: rtl/if_fetch_unit_skid_buffer.sv
// One-entry pc/instr holding register absorbing the IMEM read latency under stall.
module if_skid_buffer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        capture,
  input  logic        consume,
  input  logic        flush,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  output logic        held_valid,
  output logic [31:0] held_pc,
  output logic [31:0] held_instr
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_valid <= 1'b0;
      held_pc    <= '0;
      held_instr <= NOP_INSTR;
    end else if (flush || consume) begin
      held_valid <= 1'b0;
    end else if (capture) begin
      held_valid <= 1'b1;
      held_pc    <= in_pc;
      held_instr <= in_instr;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: PC, IMEM issue, skid-buffered {pc, instr} presentation.
// Optional IF_FETCH_STAT_EN adds fetch_count / bubble_count statistics outputs.
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
`ifdef IF_FETCH_STAT_EN
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count,
`endif
  if_fetch_unit_if.master bus
);

  run_state_e  state_q, state_d;
  logic        run;
  logic        issue;
  logic [31:0] issue_addr;
  logic [31:0] fetch_pc;
  logic        resp_valid;
  logic [31:0] resp_pc;
  logic        held_valid;
  logic [31:0] held_pc;
  logic [31:0] held_instr;
  logic        skid_capture;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == RUN_IDLE) state_d = RUN_ACTIVE;
  end

  always_comb begin
    run = (state_q == RUN_ACTIVE);
  end

  // A redirect always issues, even under stall, so the target is fetched at once.
  assign issue      = run & (redirect_valid | ~stall);
  assign issue_addr = redirect_valid ? (redirect_pc & ALIGN_MASK) : fetch_pc;
  assign bus.imem_addr = issue_addr;
  assign bus.imem_re   = issue;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc   <= RESET_PC;
      resp_valid <= 1'b0;
      resp_pc    <= '0;
    end else begin
      resp_valid <= issue;
      if (issue) begin
        fetch_pc <= issue_addr + PC_STEP;
        resp_pc  <= issue_addr;
      end
    end
  end

  assign skid_capture = stall & resp_valid & ~held_valid & ~redirect_valid;

  if_skid_buffer u_skid (
    .clk        (clk),
    .reset      (reset),
    .capture    (skid_capture),
    .consume    (~stall),
    .flush      (redirect_valid),
    .in_pc      (resp_pc),
    .in_instr   (bus.imem_rdata),
    .held_valid (held_valid),
    .held_pc    (held_pc),
    .held_instr (held_instr)
  );

  always_comb begin
    bus.if_valid     = 1'b0;
    bus.if_pc_out    = '0;
    bus.if_instr_out = NOP_INSTR;
    if (redirect_valid) begin
      bus.if_valid = 1'b0;
    end else if (held_valid) begin
      bus.if_valid     = 1'b1;
      bus.if_pc_out    = held_pc;
      bus.if_instr_out = held_instr;
    end else if (resp_valid) begin
      bus.if_valid     = 1'b1;
      bus.if_pc_out    = resp_pc;
      bus.if_instr_out = bus.imem_rdata;
    end
  end

`ifdef IF_FETCH_STAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count  <= '0;
      bubble_count <= '0;
    end else begin
      if (issue) fetch_count <= fetch_count + 32'd1;
      if (run && !stall && !bus.if_valid) bubble_count <= bubble_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed test-plan sequences plus randomized
// stall/redirect traffic checked against an instruction-stream reference model.
module tb_if_fetch_unit;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] INV = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        zero_bit = 1'b0;
  logic [31:0] zero_word = '0;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: stream of instructions by pc; warm counts edges since reset release.
  int          warm;
  logic [31:0] exp_pc;
  logic        e_valid;
  logic [31:0] e_pc;
  logic [31:0] e_instr;
  int unsigned fetch_exp, bubble_exp, fetch_pend, bubble_pend;

  if_fetch_unit_if bus ();
  if_fetch_unit_if bus2 ();

`ifdef IF_FETCH_STAT_EN
  logic [31:0] fetch_count, bubble_count, fetch_count2, bubble_count2;
`endif

  if_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
`ifdef IF_FETCH_STAT_EN
    .fetch_count    (fetch_count),
    .bubble_count   (bubble_count),
`endif
    .bus            (bus)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk            (clk),
    .reset          (reset),
    .stall          (zero_bit),
    .redirect_valid (zero_bit),
    .redirect_pc    (zero_word),
`ifdef IF_FETCH_STAT_EN
    .fetch_count    (fetch_count2),
    .bubble_count   (bubble_count2),
`endif
    .bus            (bus2)
  );

  always #5 clk = ~clk;

  // IMEM models: data = addr ^ KEY one cycle after a read, garbage otherwise.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.imem_rdata  <= '0;
      bus2.imem_rdata <= '0;
    end else begin
      bus.imem_rdata  <= bus.imem_re  ? (bus.imem_addr  ^ KEY) : $urandom;
      bus2.imem_rdata <= bus2.imem_re ? (bus2.imem_addr ^ KEY) : $urandom;
    end
  end

  always @(negedge clk) begin
    if (reset && dut.held_valid && dut.resp_valid && !redirect_valid) begin
      tests_failed++;
      $display("FAIL skid_overflow t=%0t held_valid=1 resp_valid=1 required not both", $time);
    end
  end

  task automatic apply_reset();
    reset = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    warm = 0;
    exp_pc = 32'h0;
    fetch_exp = 0; bubble_exp = 0; fetch_pend = 0; bubble_pend = 0;
    reset = 1'b1;
  endtask

  task automatic drive_cycle(input logic st, input logic rv, input logic [31:0] rp);
    @(posedge clk);
    if (warm < 2) warm++;
    fetch_exp  += fetch_pend;
    bubble_exp += bubble_pend;
    #1;
    stall = st;
    redirect_valid = rv;
    redirect_pc = rp;
    if (warm < 2 || rv) begin
      e_valid = 1'b0; e_pc = '0; e_instr = '0;
      if (warm >= 2) exp_pc = {rp[31:2], 2'b00};
    end else begin
      e_valid = 1'b1; e_pc = exp_pc; e_instr = exp_pc ^ KEY;
      if (!st) exp_pc = exp_pc + 32'd4;
    end
    fetch_pend  = (warm >= 1 && (rv || !st)) ? 1 : 0;
    bubble_pend = (warm >= 1 && !st && !e_valid) ? 1 : 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (bus.if_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", bus.if_valid); end
    tests_run++;
    if (bus.if_instr_out !== 32'h0) begin tests_failed++; $display("FAIL reset_instr got=%h exp=0", bus.if_instr_out); end
    tests_run++;
    if (bus.if_pc_out !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got=%h exp=0", bus.if_pc_out); end
    tests_run++;
    if (bus.imem_re !== 1'b0) begin tests_failed++; $display("FAIL reset_re got=%b exp=0", bus.imem_re); end
    tests_run++;
    if (bus2.imem_addr !== 32'hFFFF_FFF8) begin tests_failed++; $display("FAIL reset_addr got=%h exp=fffffff8", bus2.imem_addr); end
    apply_reset();
  endtask

  // Directed test-plan sequence: steady stream, 3-cycle stall, redirect, redirect under stall.
  task automatic test_stream();
    logic [15:0] st_bits = 16'b0011_1000_0011_1000;
    logic [15:0] rv_bits = 16'b0000_1001_0000_0000;
    logic [31:0] pc_t [16];
    pc_t = '{INV, 32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8, 32'hC,
             INV, 32'h100, 32'h104, INV, 32'h200, 32'h200, 32'h200, 32'h204};
    for (int i = 0; i < 16; i++) begin
      drive_cycle(st_bits[i], rv_bits[i], (i == 8) ? 32'h103 : 32'h200);
      tests_run++;
      if (pc_t[i] == INV) begin
        if (bus.if_valid !== 1'b0 || bus.if_instr_out !== 32'h0 || bus.if_pc_out !== 32'h0) begin
          tests_failed++;
          $display("FAIL stream_bubble cyc=%0d got valid=%b pc=%h instr=%h exp invalid/0/0",
                   i, bus.if_valid, bus.if_pc_out, bus.if_instr_out);
        end
      end else if (bus.if_valid !== 1'b1 || bus.if_pc_out !== pc_t[i] || bus.if_instr_out !== (pc_t[i] ^ KEY)) begin
        tests_failed++;
        $display("FAIL stream_out cyc=%0d got valid=%b pc=%h instr=%h exp valid=1 pc=%h instr=%h",
                 i, bus.if_valid, bus.if_pc_out, bus.if_instr_out, pc_t[i], pc_t[i] ^ KEY);
      end
      if (i == 8) begin
        tests_run++;
        if (bus.imem_re !== 1'b1 || bus.imem_addr !== 32'h100) begin
          tests_failed++;
          $display("FAIL redirect_issue got re=%b addr=%h exp re=1 addr=00000100", bus.imem_re, bus.imem_addr);
        end
      end
    end
`ifdef IF_FETCH_STAT_EN
    tests_run++;
    if (fetch_count !== fetch_exp || bubble_count !== bubble_exp) begin
      tests_failed++;
      $display("FAIL stream_stats got fetch=%0d bubble=%0d exp fetch=%0d bubble=%0d",
               fetch_count, bubble_count, fetch_exp, bubble_exp);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_cycle($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, $urandom);
      tests_run++;
      if (bus.if_valid !== e_valid || bus.if_pc_out !== e_pc || bus.if_instr_out !== e_instr) begin
        tests_failed++;
        $display("FAIL rand_out cyc=%0d got valid=%b pc=%h instr=%h exp valid=%b pc=%h instr=%h",
                 i, bus.if_valid, bus.if_pc_out, bus.if_instr_out, e_valid, e_pc, e_instr);
      end
`ifdef IF_FETCH_STAT_EN
      tests_run++;
      if (fetch_count !== fetch_exp || bubble_count !== bubble_exp) begin
        tests_failed++;
        $display("FAIL rand_stats cyc=%0d got fetch=%0d bubble=%0d exp fetch=%0d bubble=%0d",
                 i, fetch_count, bubble_count, fetch_exp, bubble_exp);
      end
`endif
    end
  endtask

  task automatic test_wrap();
    logic [31:0] wrap_t [3];
    wrap_t = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
    apply_reset();
    drive_cycle(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b0, 32'h0);
      tests_run++;
      if (bus2.if_valid !== 1'b1 || bus2.if_pc_out !== wrap_t[i] || bus2.if_instr_out !== (wrap_t[i] ^ KEY)) begin
        tests_failed++;
        $display("FAIL wrap_out idx=%0d got valid=%b pc=%h instr=%h exp pc=%h instr=%h",
                 i, bus2.if_valid, bus2.if_pc_out, bus2.if_instr_out, wrap_t[i], wrap_t[i] ^ KEY);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    repeat (4) drive_cycle(1'b0, 1'b0, 32'h0);
    repeat (2) drive_cycle(1'b1, 1'b0, 32'h0);
    tests_run++;
    if (dut.held_valid !== 1'b1) begin tests_failed++; $display("FAIL skid_full got=%b exp=1", dut.held_valid); end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (bus.if_valid !== 1'b0 || bus.if_pc_out !== 32'h0 || bus.if_instr_out !== 32'h0 ||
        bus.imem_re !== 1'b0 || bus.imem_addr !== 32'h0 || dut.held_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_out got valid=%b pc=%h instr=%h re=%b addr=%h held=%b exp all 0",
               bus.if_valid, bus.if_pc_out, bus.if_instr_out, bus.imem_re, bus.imem_addr, dut.held_valid);
    end
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 1'b0, 32'h0);
      tests_run++;
      if (bus.if_valid !== e_valid || bus.if_pc_out !== e_pc || bus.if_instr_out !== e_instr) begin
        tests_failed++;
        $display("FAIL midreset_restart cyc=%0d got valid=%b pc=%h exp valid=%b pc=%h",
                 i, bus.if_valid, bus.if_pc_out, e_valid, e_pc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
